// File: rtl/flash_responder.sv
// Avalon-MM flash stand-in: preloaded word array serving pipelined burst reads and
// single-word program writes where bits can only be cleared.
module flash_responder #(
    parameter int unsigned MEM_AW  = 8,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        flash_mem_read,
    input  logic        flash_mem_write,
    input  logic [22:0] flash_mem_address,
    input  logic [6:0]  flash_mem_burstcount,
    input  logic [3:0]  flash_mem_byteenable,
    input  logic [31:0] flash_mem_writedata,
    output logic        flash_mem_waitrequest,
    output logic [31:0] flash_mem_readdata,
    output logic        flash_mem_readdatavalid
);

    localparam int unsigned Depth = 2 ** MEM_AW;
    localparam logic [7:0] Lat = 8'(LATENCY);

    typedef enum logic [1:0] {StInit, StIdle, StRead, StWrite} state_t;

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] init_q, init_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cyc_q, cyc_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              wait_q;

    logic [31:0]       mem [Depth];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    logic [MEM_AW-1:0] addr;
    logic [31:0]       be_mask;
    logic [7:0]        req_len;
    logic [7:0]        next_cyc;
    logic [7:0]        beat_off;
    logic              unused_addr;

    assign addr        = flash_mem_address[MEM_AW-1:0];
    assign unused_addr = ^flash_mem_address[22:MEM_AW];
    assign be_mask     = {{8{flash_mem_byteenable[3]}}, {8{flash_mem_byteenable[2]}},
                          {8{flash_mem_byteenable[1]}}, {8{flash_mem_byteenable[0]}}};
    assign req_len     = (flash_mem_burstcount == 7'd0) ? 8'd1 : {1'b0, flash_mem_burstcount};
    assign next_cyc    = cyc_q + 8'd1;
    assign beat_off    = next_cyc - Lat;

    // cyc_q counts cycles since acceptance; a beat is registered one cycle before it shows.
    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        base_d    = base_q;
        len_d     = len_q;
        cyc_d     = cyc_q;
        rvalid_d  = 1'b0;
        rdata_d   = 32'd0;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = mem[addr] & (flash_mem_writedata | ~be_mask);
        case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = init_q;
                mem_wdata = 32'(init_q) * 32'd10002;
                init_d    = init_q + 1'b1;
                if (&init_q) state_d = StIdle;
            end
            StIdle: begin
                if (flash_mem_write) begin
                    mem_we  = 1'b1;
                    state_d = StWrite;
                end else if (flash_mem_read) begin
                    base_d  = addr;
                    len_d   = req_len;
                    cyc_d   = 8'd1;
                    state_d = StRead;
                    if (Lat == 8'd1) begin
                        rvalid_d = 1'b1;
                        rdata_d  = mem[addr];
                    end
                end
            end
            StRead: begin
                cyc_d = next_cyc;
                if (next_cyc >= Lat && next_cyc < Lat + len_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem[base_q + MEM_AW'(beat_off)];
                end
                if (cyc_q == Lat + len_q - 8'd1) state_d = StIdle;
            end
            StWrite: state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= StInit;
            init_q   <= '0;
            base_q   <= '0;
            len_q    <= 8'd0;
            cyc_q    <= 8'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            wait_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cyc_q    <= cyc_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            wait_q   <= (state_d != StIdle);
        end
    end

    // Array contents survive reset; INIT rewrites them.
    always_ff @(posedge clk_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign flash_mem_waitrequest   = wait_q;
    assign flash_mem_readdata      = rdata_q;
    assign flash_mem_readdatavalid = rvalid_q;

endmodule

// File: doc/flash_responder.md
# flash_responder

Synthesizable Avalon-MM responder that plays the flash side of the `flash_mem_*` data port. It lets `flash_reader` and later flash-consuming blocks be simulated, and run on the board, without the on-chip flash IP. It holds a small word-addressed array, preloaded after reset with a deterministic pattern. It serves pipelined burst reads with `waitrequest`/`readdatavalid` handshaking and single-word writes with flash program semantics (bits can only be cleared).

## Interface
- `MEM_AW`, 8: word-index width; array depth 2^`MEM_AW` words of 32 bits.
- `LATENCY`, 3: cycles from read acceptance to first `readdatavalid`; legal range 1..8.
- `clk_clk` in 1: the single clock; all logic on its rising edge.
- `reset_reset_n` in 1: reset, asynchronous, active-low.
- `flash_mem_read` in 1: read command.
- `flash_mem_write` in 1: write (program) command.
- `flash_mem_address` in 23: word address; only bits [`MEM_AW`-1:0] are used.
- `flash_mem_burstcount` in 7: read burst length in words; 0 is treated as 1; ignored for writes.
- `flash_mem_byteenable` in 4: write byte lanes; bit i covers [8i+7:8i].
- `flash_mem_writedata` in 32: program data.
- `flash_mem_waitrequest` out 1: high means no command is accepted this cycle.
- `flash_mem_readdata` out 32: read beat data; 0 whenever `readdatavalid` is low.
- `flash_mem_readdatavalid` out 1: high for exactly one cycle per returned beat.

## Operation
- States: INIT, IDLE, READ, WRITE. `waitrequest` is registered and equals (state != IDLE).
- Reset (async assert): state INIT, init index 0, beat/latency counters 0. Outputs: `waitrequest`=1, `readdatavalid`=0, `readdata`=0. Array contents are not reset.
- INIT: writes word i = (i × 10002) mod 2^32 at index i, one word per cycle for i = 0..2^`MEM_AW`−1, then goes to IDLE.
- IDLE: a command is accepted in any cycle where state is IDLE and `read` or `write` is high.
  - If both are high, the write wins and the read is dropped; it is not queued.
- READ: latches base address A and N = max(burstcount, 1).
  - Beat k (k = 0..N−1) returns array word (A + k) mod 2^`MEM_AW`. The address wraps within the array.
  - Returns to IDLE after the last beat.
- WRITE: for each enabled lane, new byte = old byte AND writedata byte; disabled lanes are unchanged. The array is updated at the end of the acceptance cycle. The block spends one cycle in WRITE, then returns to IDLE.
- Inputs are ignored outside IDLE. Holding `read` high across `waitrequest` does not re-issue the command; the initiator sees it accepted only in the IDLE cycle.
- Reset asserted mid-burst: remaining beats are abandoned, `readdatavalid` drops immediately, and INIT restarts from index 0.

## Timing
- INIT takes exactly 2^`MEM_AW` rising edges after `reset_reset_n` rises. `waitrequest` is first low in the following cycle (256 edges for `MEM_AW`=8).
- Read accepted in cycle c0:
  - `waitrequest` is high in cycles c0+1 through c0+`LATENCY`+N−1 and low again in cycle c0+`LATENCY`+N.
  - Beat k has `readdatavalid`=1 in cycle c0+`LATENCY`+k. Beats are back-to-back with no gaps.
- Write accepted in cycle c0: `waitrequest` is high in c0+1 and low in c0+2. A read accepted in c0+2 or later sees the new data.
- Throughput: N-beat read occupies `LATENCY`+N cycles; write occupies 2 cycles.

## Test plan
- Reset release -> `waitrequest` stays 1 for 256 edges then falls; `readdatavalid`=0 and `readdata`=0 throughout INIT.
- Read address 10, burstcount 4, `LATENCY` 3, accepted in c0 -> valid beats in c0+3..c0+6 with data 100020, 110022, 120024, 130026; `waitrequest` low again at c0+7.
- Read address 254, burstcount 4 -> beats from indices 254, 255, 0, 1: 2540508, 2550510, 0, 10002.
- Write address 5, writedata 0xFFFF00F0, byteenable 0001 -> word 5 goes from 0x0000C35A to 0x0000C350. A following single read returns 0x0000C350. A second write of 0xFFFFFFFF with byteenable 1111 leaves it 0x0000C350 (bits cannot be set).
- `read` and `write` both high in IDLE at address 7 -> only the program occurs, with no `readdatavalid`. Burstcount 0 read at address 7 -> exactly one beat.
- `reset_reset_n` pulsed low at beat 2 of an 8-beat burst -> `readdatavalid` is 0 from the reset edge, no further beats appear, and a fresh 256-edge INIT follows. Reads afterwards return the pattern values.
